// File: rtl/bitrev_obi_periph.sv
// OBI memory-mapped bit-reversal peripheral: four reversal modes, optional compute
// pipeline, DONE/OVERRUN status and a level interrupt.
module bitrev_obi_periph #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int PIPE_STAGES = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic            gnt_o,
    output logic            rvalid_o,
    output logic [DW-1:0]   rdata_o,
    output logic            irq_o
);
    localparam int NB = DW / 8;
    localparam int PW = (DW > 32) ? DW : 32;
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_DIN  = 2'd1;
    localparam logic [1:0] REG_DOUT = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    function automatic logic [DW-1:0] bitrev_op(input logic [DW-1:0] x,
                                                input logic [1:0]    mode,
                                                input logic [7:0]    width);
        logic [DW-1:0] r;
        int            wi;
        int            w;
        r  = '0;
        wi = int'(width);
        w  = (wi == 0 || wi > DW) ? DW : wi;
        case (mode)
            2'd0:    for (int i = 0; i < DW; i++) r[i] = x[DW-1-i];
            2'd1:    for (int b = 0; b < NB; b++) r[8*b +: 8] = x[8*(NB-1-b) +: 8];
            2'd2:    for (int i = 0; i < DW; i++) r[i] = x[(i & ~7) + 7 - (i & 7)];
            default: for (int i = 0; i < DW; i++) if (i < w) r[i] = x[w-1-i];
        endcase
        return r;
    endfunction

    logic [1:0]    sel;
    logic          busy, stall, launch, rd_dout, ctrl_wr, ovr_clr, done_evt;
    logic [DW-1:0] bmask, op_res, done_res, rd_val;
    logic [PW-1:0] wpad, mpad;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    width_q, width_d;
    logic          irqen_q, irqen_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          done_q, done_d, ovr_q, ovr_d;
    logic          rvalid_q, irq_q;
    logic [DW-1:0] rdata_q;
    logic          unused_bits;

    always_comb begin
        for (int b = 0; b < NB; b++) bmask[8*b +: 8] = {8{be_i[b]}};
    end

    assign sel     = addr_i[3:2];
    // Only accesses that would observe or disturb the in-flight result wait.
    assign stall   = busy & (((sel == REG_DOUT) & ~we_i) | ((sel == REG_DIN) & we_i));
    assign gnt_o   = req_i & ~stall & rst_ni;
    assign launch  = gnt_o & we_i & (sel == REG_DIN);
    assign rd_dout = gnt_o & ~we_i & (sel == REG_DOUT);
    assign ctrl_wr = gnt_o & we_i & (sel == REG_CTRL);
    assign ovr_clr = gnt_o & we_i & (sel == REG_STAT) & be_i[0] & wdata_i[2];
    assign wpad    = PW'(wdata_i);
    assign mpad    = PW'(bmask);
    assign op_res  = bitrev_op(wdata_i & bmask, mode_q, width_q);
    assign unused_bits = ^{addr_i[AW-1:4], addr_i[1:0], wpad, mpad};

    if (PIPE_STAGES == 0) begin : g_nopipe
        assign busy     = 1'b0;
        assign done_evt = launch;
        assign done_res = op_res;
    end else begin : g_pipe
        logic [DW-1:0]          res_p [PIPE_STAGES];
        logic [PIPE_STAGES-1:0] vld_p;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                vld_p <= '0;
            end else begin
                vld_p[0] <= launch;
                for (int k = 1; k < PIPE_STAGES; k++) vld_p[k] <= vld_p[k-1];
            end
        end

        always_ff @(posedge clk_i) begin
            res_p[0] <= op_res;
            for (int k = 1; k < PIPE_STAGES; k++) res_p[k] <= res_p[k-1];
        end

        assign busy     = |vld_p;
        assign done_evt = vld_p[PIPE_STAGES-1];
        assign done_res = res_p[PIPE_STAGES-1];
    end

    always_comb begin
        mode_d  = mode_q;
        width_d = width_q;
        irqen_d = irqen_q;
        if (ctrl_wr) begin
            if (mpad[0])  mode_d  = wpad[1:0];
            if (mpad[8])  width_d = wpad[15:8];
            if (mpad[16]) irqen_d = wpad[16];
        end
    end

    // A completion's OVERRUN set takes priority over a same-cycle W1C.
    always_comb begin
        dout_d = dout_q;
        done_d = done_q;
        ovr_d  = ovr_q;
        if (ovr_clr) ovr_d  = 1'b0;
        if (rd_dout) done_d = 1'b0;
        if (done_evt) begin
            dout_d = done_res;
            done_d = 1'b1;
            if (done_q) ovr_d = 1'b1;
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_CTRL: rd_val = DW'({15'd0, irqen_q, width_q, 6'd0, mode_q});
            REG_DOUT: rd_val = dout_q;
            REG_STAT: rd_val = DW'({ovr_q, done_q, busy});
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mode_q   <= '0;
            width_q  <= '0;
            irqen_q  <= 1'b0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            width_q  <= width_d;
            irqen_q  <= irqen_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            rvalid_q <= gnt_o;
            rdata_q  <= (gnt_o & ~we_i) ? rd_val : '0;
            irq_q    <= done_q & irqen_q;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign irq_o    = irq_q;
endmodule

// File: tb/tb_bitrev_obi_periph.sv
// Scoreboard bench for bitrev_obi_periph: two instances (PIPE_STAGES=1 and 2) driven
// with directed OBI accesses; a monitor pops expected read data on every rvalid.
module tb_bitrev_obi_periph;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [1:0] CTRL = 2'd0;
    localparam logic [1:0] DIN  = 2'd1;
    localparam logic [1:0] DOUT = 2'd2;
    localparam logic [1:0] STAT = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req    [2];
    logic          we     [2];
    logic [3:0]    be     [2];
    logic [AW-1:0] addr   [2];
    logic [DW-1:0] wdata  [2];
    logic          gnt    [2];
    logic          rvalid [2];
    logic          irq    [2];
    logic [DW-1:0] rdata  [2];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sbq0 [$];
    logic [31:0] sbq1 [$];

    always #5 clk = ~clk;

    bitrev_obi_periph #(.DW(DW), .AW(AW), .PIPE_STAGES(1)) u_dut_p1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .irq_o(irq[0])
    );

    bitrev_obi_periph #(.DW(DW), .AW(AW), .PIPE_STAGES(2)) u_dut_p2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .irq_o(irq[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid[0] === 1'b1) begin
            if (sbq0.size() == 0) check("p1 rvalid without grant", 32'(rvalid[0]), 32'd0);
            else check("p1 rdata", rdata[0], sbq0.pop_front());
        end
        if (rvalid[1] === 1'b1) begin
            if (sbq1.size() == 0) check("p2 rvalid without grant", 32'(rvalid[1]), 32'd0);
            else check("p2 rdata", rdata[1], sbq1.pop_front());
        end
    end

    task automatic access(input int d, input logic w, input logic [1:0] r,
                          input logic [31:0] wd, input logic [3:0] b,
                          input logic [31:0] exp_rd, output int waits);
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = {28'd0, r, 2'b00};
        wdata[d] = wd;
        be[d]    = b;
        waits    = 0;
        @(negedge clk);
        while (gnt[d] !== 1'b1 && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (gnt[d] !== 1'b1) check("grant timeout", 32'(gnt[d]), 32'd1);
        else if (d == 0) sbq0.push_back(w ? 32'd0 : exp_rd);
        else sbq1.push_back(w ? 32'd0 : exp_rd);
        @(posedge clk);
        #1;
        req[d]   = 1'b0;
        we[d]    = 1'b0;
        wdata[d] = '0;
        be[d]    = '0;
    endtask

    task automatic wr(input int d, input logic [1:0] r, input logic [31:0] v);
        int w;
        access(d, 1'b1, r, v, 4'hF, 32'd0, w);
    endtask

    task automatic rd(input int d, input logic [1:0] r, input logic [31:0] e);
        int w;
        access(d, 1'b0, r, 32'd0, 4'hF, e, w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; be[d] = '0; addr[d] = '0; wdata[d] = '0;
        end
        idle(2);
        // Request during reset must not be granted or answered.
        req[0] = 1'b1; addr[0] = 32'hC;
        @(negedge clk);
        check("gnt during reset", 32'(gnt[0]), 32'd0);
        check("p1 rvalid reset", 32'(rvalid[0]), 32'd0);
        check("p1 rdata reset", rdata[0], 32'd0);
        check("p1 irq reset", 32'(irq[0]), 32'd0);
        check("p2 irq reset", 32'(irq[1]), 32'd0);
        idle(1);
        req[0] = 1'b0;
        rst_n  = 1'b1;

        // Reset values and basic mode 0 latency with PIPE_STAGES=1.
        rd(0, STAT, 32'h0);
        rd(0, DOUT, 32'h0);
        rd(0, CTRL, 32'h0);
        wr(0, DIN, 32'h0000_0001);
        rd(0, STAT, 32'h1);
        rd(0, STAT, 32'h2);
        rd(0, DOUT, 32'h8000_0000);
        rd(0, STAT, 32'h0);

        // CTRL field masking and byte lanes.
        wr(0, CTRL, 32'hFFFF_FFFF);
        rd(0, CTRL, 32'h0001_FF03);
        access(0, 1'b1, CTRL, 32'h0, 4'h2, 32'h0, w);
        rd(0, CTRL, 32'h0001_0003);
        wr(0, CTRL, 32'h0);

        // Modes 1 and 2, byte-masked operand.
        wr(0, CTRL, 32'h1);
        wr(0, DIN, 32'h1122_3344);
        rd(0, DOUT, 32'h4433_2211);
        wr(0, CTRL, 32'h2);
        wr(0, DIN, 32'h0102_0304);
        rd(0, DOUT, 32'h8040_C020);
        wr(0, CTRL, 32'h1);
        access(0, 1'b1, DIN, 32'h1122_3344, 4'h1, 32'h0, w);
        rd(0, DOUT, 32'h4400_0000);

        // Mode 3 widths, including 0 and out-of-range.
        wr(0, CTRL, 32'h0000_0803);
        wr(0, DIN, 32'hFFFF_00F1);
        rd(0, DOUT, 32'h0000_008F);
        wr(0, CTRL, 32'h0000_0403);
        wr(0, DIN, 32'h0000_0001);
        rd(0, DOUT, 32'h0000_0008);
        wr(0, CTRL, 32'h0000_0003);
        wr(0, DIN, 32'h0000_0001);
        rd(0, DOUT, 32'h8000_0000);
        wr(0, CTRL, 32'h0000_2803);
        wr(0, DIN, 32'h0000_0001);
        rd(0, DOUT, 32'h8000_0000);

        // DATA_IN reads 0; writes to DATA_OUT are ignored.
        rd(0, DIN, 32'h0);
        wr(0, DOUT, 32'hDEAD_BEEF);
        rd(0, DOUT, 32'h8000_0000);

        // Overrun, W1C, and set-wins against same-cycle W1C.
        wr(0, CTRL, 32'h0);
        wr(0, DIN, 32'h1);
        wr(0, DIN, 32'h2);
        idle(3);
        rd(0, STAT, 32'h6);
        wr(0, STAT, 32'h4);
        rd(0, STAT, 32'h2);
        rd(0, DOUT, 32'h4000_0000);
        rd(0, STAT, 32'h0);
        wr(0, DIN, 32'h1);
        idle(2);
        wr(0, DIN, 32'h2);
        wr(0, STAT, 32'h4);
        rd(0, STAT, 32'h6);
        wr(0, STAT, 32'h4);
        rd(0, DOUT, 32'h4000_0000);
        rd(0, STAT, 32'h0);

        // PIPE_STAGES=2: stall length, response timing, CTRL write during BUSY.
        access(1, 1'b1, DIN, 32'h1, 4'hF, 32'h0, w);
        check("p2 DATA_IN idle wait", w, 0);
        access(1, 1'b0, DOUT, 32'h0, 4'hF, 32'h8000_0000, w);
        check("p2 stall cycles", w, 2);
        @(negedge clk);
        check("p2 rvalid one cycle after grant", 32'(rvalid[1]), 32'd1);
        idle(1);
        wr(1, DIN, 32'h1);
        access(1, 1'b1, CTRL, 32'h1, 4'hF, 32'h0, w);
        check("p2 CTRL write during busy wait", w, 0);
        rd(1, DOUT, 32'h8000_0000);
        wr(1, DIN, 32'h1122_3344);
        rd(1, DOUT, 32'h4433_2211);

        // Interrupt timing.
        wr(0, CTRL, 32'h0001_0000);
        wr(0, DIN, 32'h1);
        @(negedge clk); check("irq low while busy", 32'(irq[0]), 32'd0);
        @(negedge clk); check("irq low in DONE cycle", 32'(irq[0]), 32'd0);
        @(negedge clk); check("irq high after DONE", 32'(irq[0]), 32'd1);
        idle(1);
        rd(0, DOUT, 32'h8000_0000);
        @(negedge clk); check("irq held after read", 32'(irq[0]), 32'd1);
        @(negedge clk); check("irq low after read", 32'(irq[0]), 32'd0);
        idle(1);
        wr(0, DIN, 32'h1);
        idle(2);
        @(negedge clk); check("irq high before disable", 32'(irq[0]), 32'd1);
        idle(1);
        wr(0, CTRL, 32'h0);
        @(negedge clk);
        @(negedge clk); check("irq low after IRQ_EN clear", 32'(irq[0]), 32'd0);
        idle(1);
        rd(0, DOUT, 32'h8000_0000);

        // Reset while an operation is in flight.
        wr(0, CTRL, 32'h0001_0000);
        wr(0, DIN, 32'h1);
        rst_n = 1'b0;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'hC;
        @(negedge clk); check("gnt low in mid-op reset", 32'(gnt[0]), 32'd0);
        idle(1);
        @(negedge clk); check("gnt low in mid-op reset 2", 32'(gnt[0]), 32'd0);
        idle(1);
        req[0] = 1'b0;
        rst_n  = 1'b1;
        idle(2);
        @(negedge clk); check("irq low after reset", 32'(irq[0]), 32'd0);
        idle(1);
        rd(0, STAT, 32'h0);
        rd(0, DOUT, 32'h0);
        rd(0, CTRL, 32'h0);

        idle(3);
        check("scoreboard drained", 32'(sbq0.size() + sbq1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
